// File: rtl/cpu_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_if
//  Description : Shared instruction/data memory port between the cpu core and
//                its memory.
//  Revision    : 1.0
// ============================================================================
interface cpu_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              memory_ready;
    logic [DATA_W-1:0] in_data;
    logic              error;
    logic              memory_w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  memory_ready,
        input  in_data,
        output error,
        output memory_w,
        output addr,
        output out_data
    );

    modport slave (
        output memory_ready,
        output in_data,
        input  error,
        input  memory_w,
        input  addr,
        input  out_data
    );
endinterface
`default_nettype wire

// File: rtl/cpu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu
//  Description : 16-bit stack processor with one shared instruction/data port.
//  Revision    : 1.0
// ============================================================================
module cpu #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 16,
    parameter int RESET_PC    = 0
) (
    input  wire logic clk,
    input  wire logic rst,
    cpu_if.master     bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EXEC   = 3'd1,
        S_MEM_RD = 3'd2,
        S_MEM_WR = 3'd3,
        S_HALT   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_w_q, mem_w_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] stack_q [STACK_DEPTH];

    logic              we_a, we_b;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic [DATA_W-1:0] dat_a, dat_b;
    logic              w_fault;
    logic [DATA_W-1:0] w_alu;

    wire logic [7:0]        w_opcode = ir_q[15:8];
    wire logic [DATA_W-1:0] w_imm    = DATA_W'(ir_q[7:0]);
    wire logic [IDX_W-1:0]  w_sp_idx = sp_q[IDX_W-1:0];
    wire logic [IDX_W-1:0]  w_t_idx  = w_sp_idx - IDX_W'(1);
    wire logic [IDX_W-1:0]  w_n_idx  = w_sp_idx - IDX_W'(2);
    wire logic [DATA_W-1:0] w_t      = stack_q[w_t_idx];
    wire logic [DATA_W-1:0] w_n      = stack_q[w_n_idx];
    wire logic              w_empty  = (sp_q == '0);
    wire logic              w_has2   = (sp_q >= SP_W'(2));
    wire logic              w_full   = (sp_q == SP_W'(STACK_DEPTH));

    always_comb begin
        w_alu = '0;
        case (w_opcode)
            8'h10:   w_alu = w_n + w_t;
            8'h11:   w_alu = w_n - w_t;
            8'h12:   w_alu = w_n & w_t;
            8'h13:   w_alu = w_n | w_t;
            8'h14:   w_alu = w_n ^ w_t;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        sp_d    = sp_q;
        addr_d  = addr_q;
        mem_w_d = mem_w_q;
        wdata_d = wdata_q;
        error_d = error_q;
        we_a    = 1'b0;
        idx_a   = w_sp_idx;
        dat_a   = w_imm;
        we_b    = 1'b0;
        idx_b   = w_n_idx;
        dat_b   = w_t;
        w_fault = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (bus.memory_ready) begin
                    ir_d    = bus.in_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (w_opcode)
                    8'h00: ;
                    8'h01: begin
                        w_fault = w_full;
                        we_a    = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                    end
                    8'h02: begin
                        w_fault = w_empty;
                        we_a    = 1'b1;
                        idx_a   = w_t_idx;
                        dat_a   = {ir_q[7:0], w_t[7:0]};
                    end
                    8'h03: begin
                        w_fault = w_empty;
                        sp_d    = sp_q - SP_W'(1);
                    end
                    8'h04: begin
                        w_fault = w_empty || w_full;
                        we_a    = 1'b1;
                        dat_a   = w_t;
                        sp_d    = sp_q + SP_W'(1);
                    end
                    8'h05: begin
                        w_fault = !w_has2;
                        we_a    = 1'b1;
                        idx_a   = w_t_idx;
                        dat_a   = w_n;
                        we_b    = 1'b1;
                    end
                    8'h10, 8'h11, 8'h12, 8'h13, 8'h14: begin
                        w_fault = !w_has2;
                        we_a    = 1'b1;
                        idx_a   = w_n_idx;
                        dat_a   = w_alu;
                        sp_d    = sp_q - SP_W'(1);
                    end
                    8'h15: begin
                        w_fault = w_empty;
                        we_a    = 1'b1;
                        idx_a   = w_t_idx;
                        dat_a   = ~w_t;
                    end
                    8'h20: begin
                        w_fault = w_empty;
                        sp_d    = sp_q - SP_W'(1);
                        addr_d  = ADDR_W'(w_t);
                        state_d = S_MEM_RD;
                    end
                    8'h21: begin
                        w_fault = !w_has2;
                        sp_d    = sp_q - SP_W'(2);
                        addr_d  = ADDR_W'(w_t);
                        wdata_d = w_n;
                        mem_w_d = 1'b1;
                        state_d = S_MEM_WR;
                    end
                    8'h30: begin
                        w_fault = w_empty;
                        sp_d    = sp_q - SP_W'(1);
                        pc_d    = ADDR_W'(w_t);
                    end
                    8'h31: begin
                        w_fault = !w_has2;
                        sp_d    = sp_q - SP_W'(2);
                        if (w_n == '0) pc_d = ADDR_W'(w_t);
                    end
                    8'hFF:   state_d = S_HALT;
                    default: w_fault = 1'b1;
                endcase

                // A faulting instruction must leave stack, PC and bus untouched.
                if (w_fault) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                    mem_w_d = 1'b0;
                    we_a    = 1'b0;
                    we_b    = 1'b0;
                    sp_d    = sp_q;
                    pc_d    = pc_q;
                    addr_d  = addr_q;
                    wdata_d = wdata_q;
                end else if (state_d == S_FETCH) begin
                    addr_d = pc_d;
                end
            end
            S_MEM_RD: begin
                if (bus.memory_ready) begin
                    we_a    = 1'b1;
                    dat_a   = bus.in_data;
                    sp_d    = sp_q + SP_W'(1);
                    addr_d  = pc_q;
                    state_d = S_FETCH;
                end
            end
            S_MEM_WR: begin
                if (bus.memory_ready) begin
                    mem_w_d = 1'b0;
                    addr_d  = pc_q;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                mem_w_d = 1'b0;
            end
            S_ERROR: begin
                mem_w_d = 1'b0;
                error_d = 1'b1;
            end
            default: begin
                state_d = S_ERROR;
                error_d = 1'b1;
                mem_w_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            ir_q    <= '0;
            sp_q    <= '0;
            addr_q  <= ADDR_W'(RESET_PC);
            mem_w_q <= 1'b0;
            wdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            sp_q    <= sp_d;
            addr_q  <= addr_d;
            mem_w_q <= mem_w_d;
            wdata_q <= wdata_d;
            error_q <= error_d;
        end
    end

    // Stack storage needs no reset; SP alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (we_a) stack_q[idx_a] <= dat_a;
        if (we_b) stack_q[idx_b] <= dat_b;
    end

    assign bus.addr     = addr_q;
    assign bus.memory_w = mem_w_q;
    assign bus.out_data = wdata_q;
    assign bus.error    = error_q;
endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu
//  Description : Directed self-checking bench for the cpu stack processor.
//  Revision    : 1.0
// ============================================================================
module tb_cpu;
    logic        clk;
    logic        rst;
    logic        use_const;
    logic [15:0] mem [0:255];
    int          checks;
    int          failures;

    cpu_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    cpu #(.DATA_W(16), .ADDR_W(16), .STACK_DEPTH(16), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.in_data = use_const ? 16'h00FF : mem[bus.addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        use_const = 1'b1;
        bus.memory_ready = 1'b1;
        clear_mem();

        // NOP stream: addr 0,0,1,1,2,2...
        do_reset();
        check("reset_addr", bus.addr, 16'h0000);
        check("reset_memw", {15'd0, bus.memory_w}, 16'd0);
        check("reset_out", bus.out_data, 16'h0000);
        check("reset_err", {15'd0, bus.error}, 16'd0);
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            check("nop_addr", bus.addr, 16'(i / 2));
            check("nop_memw", {15'd0, bus.memory_w}, 16'd0);
        end
        check("nop_err", {15'd0, bus.error}, 16'd0);

        // push1 push2 add push3 store
        use_const = 1'b0;
        clear_mem();
        mem[0] = 16'h0101; mem[1] = 16'h0102; mem[2] = 16'h1000;
        mem[3] = 16'h0103; mem[4] = 16'h2100;
        do_reset();
        tick(10);
        check("st_memw", {15'd0, bus.memory_w}, 16'd1);
        check("st_addr", bus.addr, 16'h0003);
        check("st_data", bus.out_data, 16'h0003);
        tick(1);
        check("st_done_memw", {15'd0, bus.memory_w}, 16'd0);
        check("st_done_addr", bus.addr, 16'h0005);

        // Store with wait states: data 5 to 0x42
        clear_mem();
        mem[0] = 16'h0105; mem[1] = 16'h0142; mem[2] = 16'h2100;
        do_reset();
        tick(6);
        check("st2_addr", bus.addr, 16'h0042);
        check("st2_data", bus.out_data, 16'h0005);
        bus.memory_ready = 1'b0;
        tick(2);
        check("st2_hold_memw", {15'd0, bus.memory_w}, 16'd1);
        check("st2_hold_addr", bus.addr, 16'h0042);
        check("st2_hold_data", bus.out_data, 16'h0005);
        bus.memory_ready = 1'b1;
        tick(1);
        check("st2_rel_memw", {15'd0, bus.memory_w}, 16'd0);
        check("st2_rel_addr", bus.addr, 16'h0003);

        // SUB operand order: 9-3 stored to 0x50
        clear_mem();
        mem[0] = 16'h0109; mem[1] = 16'h0103; mem[2] = 16'h1100;
        mem[3] = 16'h0150; mem[4] = 16'h2100;
        do_reset();
        tick(10);
        check("sub_addr", bus.addr, 16'h0050);
        check("sub_data", bus.out_data, 16'h0006);

        // LOAD 0x10 (BEEF) then store it to 0x20
        clear_mem();
        mem[0] = 16'h0110; mem[1] = 16'h2000; mem[2] = 16'h0120;
        mem[3] = 16'h2100; mem[16] = 16'hBEEF;
        do_reset();
        tick(4);
        check("ld_rd_addr", bus.addr, 16'h0010);
        check("ld_rd_memw", {15'd0, bus.memory_w}, 16'd0);
        tick(5);
        check("ld_st_memw", {15'd0, bus.memory_w}, 16'd1);
        check("ld_st_addr", bus.addr, 16'h0020);
        check("ld_st_data", bus.out_data, 16'hBEEF);

        // LDHI/AND/SWAP: 0x1234&0x0F=4, swap with 0x60 -> store 0x60 at 4
        clear_mem();
        mem[0] = 16'h0134; mem[1] = 16'h0212; mem[2] = 16'h010F;
        mem[3] = 16'h1200; mem[4] = 16'h0160; mem[5] = 16'h0500;
        mem[6] = 16'h2100;
        do_reset();
        tick(14);
        check("swap_addr", bus.addr, 16'h0004);
        check("swap_data", bus.out_data, 16'h0060);

        // NOT/XOR: ~0xF0 ^ 0x33 = FF3C at 0x40
        clear_mem();
        mem[0] = 16'h01F0; mem[1] = 16'h1500; mem[2] = 16'h0133;
        mem[3] = 16'h1400; mem[4] = 16'h0140; mem[5] = 16'h2100;
        do_reset();
        tick(12);
        check("xor_addr", bus.addr, 16'h0040);
        check("xor_data", bus.out_data, 16'hFF3C);

        // OR: 0x81|0x02 = 0x83 at 0x41
        clear_mem();
        mem[0] = 16'h0181; mem[1] = 16'h0102; mem[2] = 16'h1300;
        mem[3] = 16'h0141; mem[4] = 16'h2100;
        do_reset();
        tick(10);
        check("or_addr", bus.addr, 16'h0041);
        check("or_data", bus.out_data, 16'h0083);

        // Fetch stall: ready low 3 cycles
        use_const = 1'b1;
        do_reset();
        bus.memory_ready = 1'b0;
        tick(3);
        check("stall_addr", bus.addr, 16'h0000);
        bus.memory_ready = 1'b1;
        tick(2);
        check("stall_pc", bus.addr, 16'h0001);
        use_const = 1'b0;

        // Undefined opcode, sticky error, async reset
        clear_mem();
        mem[0] = 16'h7700;
        do_reset();
        tick(1);
        check("undef_err_exec", {15'd0, bus.error}, 16'd0);
        tick(1);
        check("undef_err", {15'd0, bus.error}, 16'd1);
        tick(3);
        check("undef_sticky", {15'd0, bus.error}, 16'd1);
        check("undef_memw", {15'd0, bus.memory_w}, 16'd0);
        rst = 1'b1;
        #1;
        check("arst_err", {15'd0, bus.error}, 16'd0);
        check("arst_addr", bus.addr, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Underflow on empty POP
        clear_mem();
        mem[0] = 16'h0300;
        do_reset();
        tick(2);
        check("uflow_err", {15'd0, bus.error}, 16'd1);

        // Overflow on 17th PUSHI
        clear_mem();
        for (int i = 0; i < 17; i++) mem[i] = 16'h0100 | 16'(i);
        do_reset();
        tick(32);
        check("oflow_pre_err", {15'd0, bus.error}, 16'd0);
        check("oflow_pre_addr", bus.addr, 16'h0010);
        tick(2);
        check("oflow_err", {15'd0, bus.error}, 16'd1);

        // JZ taken
        clear_mem();
        mem[0] = 16'h0100; mem[1] = 16'h0120; mem[2] = 16'h3100;
        do_reset();
        tick(6);
        check("jz_taken", bus.addr, 16'h0020);

        // JZ not taken
        clear_mem();
        mem[0] = 16'h0101; mem[1] = 16'h0120; mem[2] = 16'h3100;
        do_reset();
        tick(6);
        check("jz_fall", bus.addr, 16'h0003);

        // JMP
        clear_mem();
        mem[0] = 16'h0130; mem[1] = 16'h3000;
        do_reset();
        tick(4);
        check("jmp", bus.addr, 16'h0030);

        // HALT holds address, no error
        clear_mem();
        mem[0] = 16'hFF00;
        do_reset();
        tick(6);
        check("halt_addr", bus.addr, 16'h0000);
        check("halt_err", {15'd0, bus.error}, 16'd0);
        check("halt_memw", {15'd0, bus.memory_w}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
